// File: rtl/lsu_master.sv
// Load/store initiator: turns execute-stage memory ops into word-bus beats,
// splitting accesses that straddle a 32-bit word into two beats, and returns
// extended load data with its destination register to writeback.
module lsu_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  info_load_i,
    input  logic [1:0]  info_store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  dst_addr_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rd_data_o,
    output logic        w_reg_o,
    output logic [4:0]  dst_addr_d_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_e;

    localparam logic [2:0] LdLb  = 3'd1;
    localparam logic [2:0] LdLh  = 3'd2;
    localparam logic [2:0] LdLw  = 3'd3;
    localparam logic [2:0] LdLbu = 3'd4;
    localparam logic [2:0] LdLhu = 3'd5;

    state_e      state_q;
    logic        store_q;
    logic        split_q;
    logic [2:0]  ltype_q;
    logic [1:0]  rem_q;
    logic [4:0]  dst_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;
    logic [31:0] lo_q;

    logic        mem_valid_q;
    logic        mem_we_q;
    logic [29:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rd_data_q;
    logic        w_reg_q;
    logic [4:0]  dst_addr_q;

    // Accept-side decode: size, lane-shifted byte enables and data, split detection
    logic        acc_store;
    logic        acc_load;
    logic [2:0]  acc_size;
    logic [7:0]  acc_be8;
    logic [63:0] acc_wd64;
    logic        acc_split;

    always_comb begin
        acc_store = (info_store_i != 2'd0);
        acc_load  = !acc_store && (info_load_i >= LdLb) && (info_load_i <= LdLhu);
        acc_size  = 3'd0;
        if (acc_store) begin
            unique case (info_store_i)
                2'd1:    acc_size = 3'd1;
                2'd2:    acc_size = 3'd2;
                default: acc_size = 3'd4;
            endcase
        end else if (acc_load) begin
            unique case (info_load_i)
                LdLb, LdLbu: acc_size = 3'd1;
                LdLh, LdLhu: acc_size = 3'd2;
                default:     acc_size = 3'd4;
            endcase
        end
        unique case (acc_size)
            3'd1:    acc_be8 = 8'h01 << addr_i[1:0];
            3'd2:    acc_be8 = 8'h03 << addr_i[1:0];
            3'd4:    acc_be8 = 8'h0F << addr_i[1:0];
            default: acc_be8 = 8'h00;
        endcase
        acc_wd64  = {32'd0, wdata_i} << {addr_i[1:0], 3'b000};
        acc_split = ({1'b0, addr_i[1:0]} + acc_size) > 3'd4;
    end

    // Load result: align the captured word pair to the access offset, then extend
    logic [31:0] lo_sel;
    logic [31:0] hi_sel;
    logic [63:0] raw64;
    logic [31:0] load_ext;
    logic        unused_raw_hi;

    always_comb begin
        lo_sel   = (state_q == StWait0) ? mem_rdata_i : lo_q;
        hi_sel   = (state_q == StWait1) ? mem_rdata_i : 32'd0;
        raw64    = {hi_sel, lo_sel} >> {rem_q, 3'b000};
        load_ext = raw64[31:0];
        unique case (ltype_q)
            LdLb:    load_ext = {{24{raw64[7]}}, raw64[7:0]};
            LdLh:    load_ext = {{16{raw64[15]}}, raw64[15:0]};
            LdLbu:   load_ext = {24'd0, raw64[7:0]};
            LdLhu:   load_ext = {16'd0, raw64[15:0]};
            default: load_ext = raw64[31:0];
        endcase
    end

    assign unused_raw_hi = ^raw64[63:32];

    // Control FSM with all bus and writeback outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            store_q     <= 1'b0;
            split_q     <= 1'b0;
            ltype_q     <= 3'd0;
            rem_q       <= 2'd0;
            dst_q       <= 5'd0;
            be_hi_q     <= 4'd0;
            wd_hi_q     <= 32'd0;
            lo_q        <= 32'd0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rd_data_q   <= 32'd0;
            w_reg_q     <= 1'b0;
            dst_addr_q  <= 5'd0;
        end else begin
            w_reg_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Ops with neither load nor store are swallowed without bus activity
                    if (req_valid_i && (acc_store || acc_load)) begin
                        store_q     <= acc_store;
                        split_q     <= acc_split;
                        ltype_q     <= info_load_i;
                        rem_q       <= addr_i[1:0];
                        dst_q       <= dst_addr_i;
                        be_hi_q     <= acc_be8[7:4];
                        wd_hi_q     <= acc_wd64[63:32];
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= acc_store;
                        mem_addr_q  <= addr_i[31:2];
                        mem_be_q    <= acc_be8[3:0];
                        mem_wdata_q <= acc_wd64[31:0];
                        state_q     <= StReq0;
                    end
                end
                StReq0: begin
                    if (mem_ready_i) begin
                        if (store_q && split_q) begin
                            // Second store beat follows back-to-back
                            mem_addr_q  <= mem_addr_q + 30'd1;
                            mem_be_q    <= be_hi_q;
                            mem_wdata_q <= wd_hi_q;
                            state_q     <= StReq1;
                        end else begin
                            mem_valid_q <= 1'b0;
                            mem_we_q    <= 1'b0;
                            state_q     <= store_q ? StIdle : StWait0;
                        end
                    end
                end
                StWait0: begin
                    if (mem_rvalid_i) begin
                        lo_q <= mem_rdata_i;
                        if (split_q) begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= mem_addr_q + 30'd1;
                            mem_be_q    <= be_hi_q;
                            mem_wdata_q <= wd_hi_q;
                            state_q     <= StReq1;
                        end else begin
                            rd_data_q  <= load_ext;
                            dst_addr_q <= dst_q;
                            w_reg_q    <= 1'b1;
                            state_q    <= StResp;
                        end
                    end
                end
                StReq1: begin
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        state_q     <= store_q ? StIdle : StWait1;
                    end
                end
                StWait1: begin
                    if (mem_rvalid_i) begin
                        rd_data_q  <= load_ext;
                        dst_addr_q <= dst_q;
                        w_reg_q    <= 1'b1;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign mem_valid_o  = mem_valid_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign rd_data_o    = rd_data_q;
    assign w_reg_o      = w_reg_q;
    assign dst_addr_d_o = dst_addr_q;

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: hand-computed vectors, immediate-assertion checks.
module tb_lsu_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  info_load_i;
    logic [1:0]  info_store_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  dst_addr_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rd_data_o;
    logic        w_reg_o;
    logic [4:0]  dst_addr_d_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .info_load_i  (info_load_i),
        .info_store_i (info_store_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dst_addr_i   (dst_addr_i),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rd_data_o    (rd_data_o),
        .w_reg_o      (w_reg_o),
        .dst_addr_d_o (dst_addr_d_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; on return the DUT has taken it
    task automatic issue(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] dst);
        req_valid_i  = 1'b1;
        info_load_i  = ld;
        info_store_i = st;
        addr_i       = a;
        wdata_i      = wd;
        dst_addr_i   = dst;
        step();
        req_valid_i  = 1'b0;
        info_load_i  = 3'd0;
        info_store_i = 2'd0;
    endtask

    // From REQ with mem_ready high: request is taken, then one read word returns
    task automatic serve_read(input logic [31:0] word);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = word;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        info_load_i  = 3'd0;
        info_store_i = 2'd0;
        addr_i       = 32'd0;
        wdata_i      = 32'd0;
        dst_addr_i   = 5'd0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        step();
        step();

        // Reset values
        chk("rst mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst mem_addr", {2'd0, mem_addr_o}, 32'd0);
        chk("rst mem_be", {28'd0, mem_be_o}, 32'd0);
        chk("rst mem_wdata", mem_wdata_o, 32'd0);
        chk("rst rd_data", rd_data_o, 32'd0);
        chk("rst w_reg", {31'd0, w_reg_o}, 32'd0);
        chk("rst dst", {27'd0, dst_addr_d_o}, 32'd0);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready_o}, 32'd1);
        rst_n = 1'b1;
        step();

        // Lw 0x100, zero-wait bus
        issue(3'd3, 2'd0, 32'h0000_0100, 32'd0, 5'd7);
        chk("lw valid", {31'd0, mem_valid_o}, 32'd1);
        chk("lw addr", {2'd0, mem_addr_o}, 32'h40);
        chk("lw be", {28'd0, mem_be_o}, 32'hF);
        chk("lw we", {31'd0, mem_we_o}, 32'd0);
        chk("lw busy", {31'd0, busy_o}, 32'd1);
        chk("lw req_ready", {31'd0, req_ready_o}, 32'd0);
        step();
        chk("lw wait valid", {31'd0, mem_valid_o}, 32'd0);
        chk("lw wait w_reg", {31'd0, w_reg_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        step();
        mem_rvalid_i = 1'b0;
        chk("lw w_reg", {31'd0, w_reg_o}, 32'd1);
        chk("lw rd_data", rd_data_o, 32'hDEAD_BEEF);
        chk("lw dst", {27'd0, dst_addr_d_o}, 32'd7);
        chk("lw resp ready", {31'd0, req_ready_o}, 32'd0);
        step();
        chk("lw w_reg drop", {31'd0, w_reg_o}, 32'd0);
        chk("lw idle ready", {31'd0, req_ready_o}, 32'd1);
        chk("lw rd hold", rd_data_o, 32'hDEAD_BEEF);

        // Op with no load and no store: accepted, no bus activity
        issue(3'd0, 2'd0, 32'h0000_0200, 32'd0, 5'd1);
        chk("nop busy", {31'd0, busy_o}, 32'd0);
        chk("nop valid", {31'd0, mem_valid_o}, 32'd0);

        // Sb 0x103: single beat, top lane
        issue(3'd0, 2'd1, 32'h0000_0103, 32'h0000_00A5, 5'd2);
        chk("sb valid", {31'd0, mem_valid_o}, 32'd1);
        chk("sb addr", {2'd0, mem_addr_o}, 32'h40);
        chk("sb be", {28'd0, mem_be_o}, 32'h8);
        chk("sb wdata", mem_wdata_o, 32'hA500_0000);
        chk("sb we", {31'd0, mem_we_o}, 32'd1);
        step();
        chk("sb done busy", {31'd0, busy_o}, 32'd0);
        chk("sb done valid", {31'd0, mem_valid_o}, 32'd0);
        chk("sb no w_reg", {31'd0, w_reg_o}, 32'd0);
        chk("sb rd hold", rd_data_o, 32'hDEAD_BEEF);

        // Lb / Lbu / Lhu at offset 2
        issue(3'd1, 2'd0, 32'h0000_0102, 32'd0, 5'd3);
        chk("lb be", {28'd0, mem_be_o}, 32'h4);
        serve_read(32'h0080_0000);
        chk("lb w_reg", {31'd0, w_reg_o}, 32'd1);
        chk("lb rd_data", rd_data_o, 32'hFFFF_FF80);
        chk("lb dst", {27'd0, dst_addr_d_o}, 32'd3);
        step();
        issue(3'd4, 2'd0, 32'h0000_0102, 32'd0, 5'd4);
        serve_read(32'h0080_0000);
        chk("lbu rd_data", rd_data_o, 32'h0000_0080);
        step();
        issue(3'd5, 2'd0, 32'h0000_0102, 32'd0, 5'd4);
        chk("lhu be", {28'd0, mem_be_o}, 32'hC);
        serve_read(32'h8001_1234);
        chk("lhu rd_data", rd_data_o, 32'h0000_8001);
        step();

        // Sw 0x0FE: split store, back-to-back beats
        issue(3'd0, 2'd3, 32'h0000_00FE, 32'h1122_3344, 5'd0);
        chk("sw b0 addr", {2'd0, mem_addr_o}, 32'h3F);
        chk("sw b0 be", {28'd0, mem_be_o}, 32'hC);
        chk("sw b0 wdata", mem_wdata_o, 32'h3344_0000);
        chk("sw b0 we", {31'd0, mem_we_o}, 32'd1);
        step();
        chk("sw b1 valid", {31'd0, mem_valid_o}, 32'd1);
        chk("sw b1 addr", {2'd0, mem_addr_o}, 32'h40);
        chk("sw b1 be", {28'd0, mem_be_o}, 32'h3);
        chk("sw b1 wdata", mem_wdata_o, 32'h0000_1122);
        chk("sw b1 we", {31'd0, mem_we_o}, 32'd1);
        step();
        chk("sw done busy", {31'd0, busy_o}, 32'd0);
        chk("sw done valid", {31'd0, mem_valid_o}, 32'd0);

        // Lh 0xFFFFFFFF: split with address wrap and a stalled bus
        mem_ready_i = 1'b0;
        issue(3'd2, 2'd0, 32'hFFFF_FFFF, 32'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            chk("lh stall valid", {31'd0, mem_valid_o}, 32'd1);
            chk("lh stall addr", {2'd0, mem_addr_o}, 32'h3FFF_FFFF);
            chk("lh stall be", {28'd0, mem_be_o}, 32'h8);
            chk("lh stall we", {31'd0, mem_we_o}, 32'd0);
            step();
        end
        chk("lh stall end valid", {31'd0, mem_valid_o}, 32'd1);
        mem_ready_i = 1'b1;
        step();
        chk("lh wait0 valid", {31'd0, mem_valid_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hAB00_0000;
        step();
        mem_rvalid_i = 1'b0;
        chk("lh b1 valid", {31'd0, mem_valid_o}, 32'd1);
        chk("lh b1 addr", {2'd0, mem_addr_o}, 32'h0);
        chk("lh b1 be", {28'd0, mem_be_o}, 32'h1);
        chk("lh b1 w_reg", {31'd0, w_reg_o}, 32'd0);
        step();
        chk("lh wait1 valid", {31'd0, mem_valid_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00CD;
        step();
        mem_rvalid_i = 1'b0;
        chk("lh w_reg", {31'd0, w_reg_o}, 32'd1);
        chk("lh rd_data", rd_data_o, 32'hFFFF_CDAB);
        chk("lh dst", {27'd0, dst_addr_d_o}, 32'd9);
        step();

        // Reset during WAIT0 aborts the load; stray rvalid afterwards is ignored
        issue(3'd3, 2'd0, 32'h0000_0200, 32'd0, 5'd5);
        step();
        chk("abort in wait0", {31'd0, mem_valid_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort valid", {31'd0, mem_valid_o}, 32'd0);
        chk("abort busy", {31'd0, busy_o}, 32'd0);
        chk("abort rd_data", rd_data_o, 32'd0);
        step();
        rst_n        = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort no w_reg", {31'd0, w_reg_o}, 32'd0);
            chk("abort idle", {31'd0, busy_o}, 32'd0);
        end
        mem_rvalid_i = 1'b0;
        chk("abort rd keep", rd_data_o, 32'd0);
        issue(3'd3, 2'd0, 32'h0000_0200, 32'd0, 5'd5);
        chk("relw addr", {2'd0, mem_addr_o}, 32'h80);
        serve_read(32'h1234_5678);
        chk("relw w_reg", {31'd0, w_reg_o}, 32'd1);
        chk("relw rd_data", rd_data_o, 32'h1234_5678);
        chk("relw dst", {27'd0, dst_addr_d_o}, 32'd5);
        step();
        chk("relw idle", {31'd0, req_ready_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
